book_mem_arbiter: RTL and testbench
===================================

# book_mem_arbiter

Multi-channel access manager for the order-book entry memory. Up to N_CH requesters (book-update engine, top-of-book scanner, ...) share one single-port book memory through a fully pipelined arbiter. The arbiter issues one operation per cycle and returns read data and per-channel completion strobes in issue order. It replaces the single-requester, one-operation-in-flight memory manager in the order-book datapath.

## Interface
- N_CH, 2: number of requester channels, 1..8
- ADDR_W, ADDRESS_INDEX+1: address width
- DEPTH, 2**ADDR_W: number of book_entry words
- LATENCY, BRAM_LATENCY: memory read latency in cycles, ≥1

Ports:
- clk_in  in  1  sole clock, rising edge
- rst_in  in  1  synchronous, active-high reset
- req  in  [N_CH]  per-channel request; held with its payload until ack
- is_write  in  [N_CH]  1 = write, 0 = read
- addr  in  [N_CH][ADDR_W]  per-channel address
- data_i  in  [N_CH] book_entry  per-channel write data
- ack  out  [N_CH]  combinational one-hot grant; request is accepted at the edge where req&ack=1
- data_o  out  book_entry  shared read-data bus, qualified by valid
- valid  out  [N_CH]  one-cycle completion strobe, at most one bit set
- busy  out  1  any operation in flight

## Operation
- Grant: each cycle at most one ack bit is set, and only for a channel with req=1. ack=0 while rst_in=1.
- An accepted operation enters the memory at that edge. A write commits to memory at the accept edge.
- Issue pipeline: LATENCY stages. Each stage carries {vld, ch, is_write}. It advances every cycle with no stall.
- Completion: when the tag leaves the last stage, valid[ch] pulses for one cycle.
  - Read: data_o = memory word at the issue-time address.
  - Write: data_o = data written (write-first).
- Completions are in issue order. A read accepted after a write to the same address returns the new data, including back-to-back cycles and different channels.
- Between completions, data_o holds its last value.
- busy = OR of all stage vld bits.
- Sustained throughput: one operation per cycle aggregate.
- Reset: ack, valid, busy = 0; data_o = '0; all stage vld cleared; round-robin pointer = N_CH-1.
  - In-flight operations are dropped and produce no valid.
  - Writes already committed remain. Memory contents are not cleared.
- Out-of-range address (≥DEPTH when DEPTH < 2**ADDR_W):
  - Write is discarded.
  - Read returns '0.
  - valid still pulses.

## Timing
- Request accepted at edge E; valid[ch] and data_o are high/valid in the cycle following edge E+LATENCY.
- Minimum req-to-valid with immediate grant: LATENCY+1 edges.
- A channel may hold req high continuously. It receives a new grant whenever the arbiter selects it.
- Multiple in-flight operations from one channel are allowed.
- The requester drops or changes its payload in the cycle after ack.

## Configuration
- MEMARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. The search starts at (last_granted+1) mod N_CH.
  - The pointer updates only on a grant.
  - With all channels requesting, each channel is granted once every N_CH cycles.
- Not defined:
  - Fixed priority, lowest index wins.
  - No pointer register is instantiated.

## Structure
- Shared package (constants.sv): book_entry typedef, ADDRESS_INDEX, BRAM_LATENCY, and a new mem_tag_t struct {vld, ch, is_write}.
- One sub-module: book_bram.
  - Inferred single-port write-first RAM with parameters ADDR_W, DEPTH, LATENCY.
  - Output pipeline of LATENCY registers.
- The arbiter and tag pipeline live in book_mem_arbiter.

## Test plan
- Single write then read, N_CH=2, LATENCY=2:
  - ch0 writes A to addr 5; ch0 reads addr 5.
  - Expect valid[0] 3 edges after each accept; data_o=A on the read.
- Back-to-back RAW across channels:
  - ch1 writes B to addr 9 at edge E; ch0 reads addr 9 at E+1.
  - Expect valid[1] at E+LATENCY, then valid[0] at E+1+LATENCY with data_o=B.
- Contention with MEMARB_ROUND_ROBIN_EN, N_CH=3, all req held 9 cycles:
  - Expect ack sequence 0,1,2,0,1,2,0,1,2 and valid in the same order.
  - Without the macro: ack[0] every cycle.
- Reset mid-flight:
  - Issue 2 reads and 1 write, assert rst_in at the next edge.
  - Expect no valid, busy=0, data_o=0 after reset.
  - A subsequent read of the written address returns the written value.
- Out-of-range, DEPTH=24, ADDR_W=5:
  - Write to addr 30, then read addr 30.
  - Expect read data_o='0, both valids pulsed, no corruption of addr 30 mod 24.
- Throughput: 64 random reads/writes from 2 channels.
  - Expect exactly 64 valid pulses.
  - Every read matches the scoreboard model; busy falls LATENCY+1 cycles after the last accept.

Source files
------------

// File: rtl/book_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// book_mem_arbiter_pkg
// Shared order-book memory types and constants.
//   book_entry    : one order-book memory word (price / quantity / flags)
//   ADDRESS_INDEX : top bit index of the book address (address width - 1)
//   BRAM_LATENCY  : default read latency of the book memory, in cycles
//   mem_tag_t     : per-stage tag carried alongside an issued memory operation
// -----------------------------------------------------------------------------
package book_mem_arbiter_pkg;

  localparam int ADDRESS_INDEX = 4;
  localparam int BRAM_LATENCY  = 2;

  // Channel index field is sized for the largest supported channel count (8).
  localparam int CH_IDX_W = 3;

  typedef struct packed {
    logic [31:0] price;
    logic [23:0] qty;
    logic [7:0]  flags;
  } book_entry;

  typedef struct packed {
    logic                vld;
    logic [CH_IDX_W-1:0] ch;
    logic                is_write;
  } mem_tag_t;

endpackage

// File: rtl/book_mem_arbiter_book_bram.sv
// -----------------------------------------------------------------------------
// book_bram
// Inferred single-port, write-first book memory with a LATENCY-deep registered
// read path.
//   clk_in : clock, rising edge
//   en     : an operation is presented this cycle
//   we     : 1 = write, 0 = read
//   addr   : word address (values >= DEPTH are out of range)
//   wdata  : write data
//   rdata  : result of the operation issued LATENCY edges earlier
// Out-of-range writes are discarded and out-of-range reads return zero. A write
// returns its own data (write-first). Memory contents are never cleared.
// -----------------------------------------------------------------------------
module book_bram
  import book_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_INDEX + 1,
  parameter int DEPTH   = 2 ** ADDR_W,
  parameter int LATENCY = BRAM_LATENCY
) (
  input  logic              clk_in,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  book_entry         wdata,
  output book_entry         rdata
);

  book_entry mem_reg  [DEPTH];
  book_entry pipe_reg [LATENCY];
  logic      in_range;

  // One extra bit so the compare also works when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk_in) begin
    if (en && we && in_range) begin
      mem_reg[addr] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (en) begin
      if (we) begin
        pipe_reg[0] <= wdata;
      end else if (!in_range) begin
        pipe_reg[0] <= '0;
      end else begin
        pipe_reg[0] <= mem_reg[addr];
      end
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign rdata = pipe_reg[LATENCY-1];

endmodule

// File: rtl/book_mem_arbiter.sv
// -----------------------------------------------------------------------------
// book_mem_arbiter
// Pipelined N_CH-channel access manager for the single-port book memory.
// One operation is granted per cycle; completions return in issue order.
//   clk_in   : clock, rising edge
//   rst_in   : synchronous active-high reset (drops in-flight operations)
//   req      : per-channel request, payload held until ack
//   is_write : per-channel 1 = write, 0 = read
//   addr     : per-channel address
//   data_i   : per-channel write data
//   ack      : combinational one-hot grant, accepted where req & ack
//   data_o   : shared result bus, qualified by valid, holds between completions
//   valid    : one-cycle completion strobe per channel
//   busy     : any operation in the issue pipeline
// Build option: MEMARB_ROUND_ROBIN_EN selects round-robin arbitration; without
// it the lowest requesting channel index always wins.
// -----------------------------------------------------------------------------
module book_mem_arbiter
  import book_mem_arbiter_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = ADDRESS_INDEX + 1,
  parameter int DEPTH   = 2 ** ADDR_W,
  parameter int LATENCY = BRAM_LATENCY
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [N_CH-1:0]               req,
  input  logic [N_CH-1:0]               is_write,
  input  logic [N_CH-1:0][ADDR_W-1:0]   addr,
  input  book_entry [N_CH-1:0]          data_i,
  output logic [N_CH-1:0]               ack,
  output book_entry                     data_o,
  output logic [N_CH-1:0]               valid,
  output logic                          busy
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  book_entry         sel_data;
  book_entry         bram_rdata;
  mem_tag_t          tag_reg [LATENCY];
  logic [N_CH-1:0]   valid_next;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEMARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] ptr_reg;
  int              cand;
  logic [CH_W-1:0] cand_idx;

  // Walk from the farthest candidate to the nearest so that the channel right
  // after the last grant ends up winning.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand     = (int'(ptr_reg) + k) % N_CH;
      cand_idx = CH_W'(cand);
      if (req[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_reg <= CH_W'(N_CH - 1);
    end else if (accept) begin
      ptr_reg <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(k);
      end
    end
  end
`endif

  assign accept = grant_any && !rst_in;

  always_comb begin
    ack = '0;
    if (accept) begin
      ack[grant_idx] = 1'b1;
    end
  end

  assign sel_we   = is_write[grant_idx];
  assign sel_addr = addr[grant_idx];
  assign sel_data = data_i[grant_idx];

  // ---------------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------------
  book_bram #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_bram (
    .clk_in (clk_in),
    .en     (accept),
    .we     (sel_we),
    .addr   (sel_addr),
    .wdata  (sel_data),
    .rdata  (bram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Tag pipeline: runs in lock-step with the memory read path, never stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_reg[i] <= '0;
      end
    end else begin
      tag_reg[0].vld      <= accept;
      tag_reg[0].ch       <= CH_IDX_W'(grant_idx);
      tag_reg[0].is_write <= sel_we;
      for (int i = 1; i < LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | tag_reg[i].vld;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      valid_next[c] = tag_reg[LATENCY-1].vld &&
                      (tag_reg[LATENCY-1].ch == CH_IDX_W'(c));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid  <= '0;
      data_o <= '0;
    end else begin
      valid <= valid_next;
      if (tag_reg[LATENCY-1].vld) begin
        data_o <= bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_book_mem_arbiter.sv
module tb_book_mem_arbiter;
  import book_mem_arbiter_pkg::*;

  localparam int N_CH    = 3;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 24;
  localparam int LATENCY = 2;

  logic                        clk_in = 1'b0;
  logic                        rst_in;
  logic [N_CH-1:0]             req;
  logic [N_CH-1:0]             is_write;
  logic [N_CH-1:0][ADDR_W-1:0] addr;
  book_entry [N_CH-1:0]        data_i;
  logic [N_CH-1:0]             ack;
  book_entry                   data_o;
  logic [N_CH-1:0]             valid;
  logic                        busy;

  book_mem_arbiter #(
    .N_CH    (N_CH),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .req      (req),
    .is_write (is_write),
    .addr     (addr),
    .data_i   (data_i),
    .ack      (ack),
    .data_o   (data_o),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          ch;
    logic [63:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [DEPTH];
  bit          known [DEPTH];
  int          cyc      = 0;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          vcnt     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge, then check the completion strobe against the scoreboard.
  task automatic tick();
    logic [63:0] exp_v;
    exp_t        e;
    @(posedge clk_in);
    #1;
    cyc++;
    exp_v = 64'd0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) exp_v = 64'd1 << exp_q[0].ch;
    if (valid != 0) vcnt++;
    check($sformatf("valid@%0d", cyc), {61'd0, valid}, exp_v);
    if (exp_v != 0) begin
      e = exp_q.pop_front();
      if (e.chk) check($sformatf("data_o@%0d", cyc), data_o, e.data);
    end
  endtask

  task automatic push_exp(input int ch, input bit w, input int a, input logic [63:0] d);
    exp_t e;
    e.ch   = ch;
    e.due  = cyc + 1 + LATENCY;
    e.data = w ? d : ((a >= DEPTH) ? 64'd0 : model[a]);
    e.chk  = w || (a >= DEPTH) || known[a];
    exp_q.push_back(e);
    if (w && a < DEPTH) begin
      model[a] = d;
      known[a] = 1'b1;
    end
  endtask

  // One request from a single channel, accepted at the next edge.
  task automatic drive(input int ch, input bit w, input int a, input logic [63:0] d);
    req          = '0;
    req[ch]      = 1'b1;
    is_write[ch] = w;
    addr[ch]     = ADDR_W'(a);
    data_i[ch]   = d;
    #1;
    check($sformatf("ack ch%0d", ch), {61'd0, ack}, 64'd1 << ch);
    push_exp(ch, w, a, d);
    tick();
    req = '0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    bit w;
    int ch;
    int a;
    logic [63:0] d;

    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 64'd0;
      known[i] = 1'b0;
    end
    rst_in   = 1'b1;
    req      = '0;
    is_write = '0;
    addr     = '0;
    data_i   = '0;
    tick();
    tick();
    req = 3'b111;
    #1;
    check("ack_in_reset", {61'd0, ack}, 64'd0);
    check("busy_reset", {63'd0, busy}, 64'd0);
    check("data_o_reset", data_o, 64'd0);
    req    = '0;
    rst_in = 1'b0;
    tick();

    // Contention: all three channels write continuously for 9 cycles.
    req = 3'b111;
    is_write = 3'b111;
    for (int i = 0; i < N_CH; i++) begin
      addr[i]   = ADDR_W'(10 + i);
      data_i[i] = 64'hC0C0_0000_0000_0000 + 64'(i);
    end
    for (int n = 0; n < 9; n++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      g = n % N_CH;
`else
      g = 0;
`endif
      #1;
      check($sformatf("contention_ack%0d", n), {61'd0, ack}, 64'd1 << g);
      push_exp(g, 1'b1, 10 + g, 64'hC0C0_0000_0000_0000 + 64'(g));
      tick();
    end
    req = '0;
    is_write = '0;
    drain(4);

    // Single write then read on ch0.
    drive(0, 1'b1, 5, 64'hAAAA_1111_2222_0005);
    drain(3);
    drive(0, 1'b0, 5, 64'd0);
    drain(3);

    // Back-to-back read-after-write across channels.
    drive(1, 1'b1, 9, 64'hBBBB_3333_4444_0009);
    drive(0, 1'b0, 9, 64'd0);
    drain(3);

    // Reset with operations in flight.
    drive(0, 1'b0, 5, 64'd0);
    drive(1, 1'b0, 9, 64'd0);
    drive(2, 1'b1, 12, 64'hDDDD_5555_6666_000C);
    check("busy_inflight", {63'd0, busy}, 64'd1);
    rst_in = 1'b1;
    exp_q.delete();
    tick();
    check("busy_after_rst", {63'd0, busy}, 64'd0);
    check("data_o_after_rst", data_o, 64'd0);
    rst_in = 1'b0;
    tick();
    tick();
    drive(0, 1'b0, 12, 64'd0);
    drain(3);

    // Out-of-range accesses (DEPTH=24).
    drive(0, 1'b1, 6, 64'h6666_0000_0000_0006);
    drive(1, 1'b1, 30, 64'h3030_0000_0000_001E);
    drive(0, 1'b0, 30, 64'd0);
    drive(1, 1'b0, 6, 64'd0);
    drain(3);

    // Throughput: 64 back-to-back random operations from channels 0 and 1.
    vcnt = 0;
    for (int n = 0; n < 64; n++) begin
      ch = int'($urandom_range(0, 1));
      w  = bit'($urandom_range(0, 1));
      a  = int'($urandom_range(0, DEPTH - 1));
      d  = {$urandom, $urandom};
      drive(ch, w, a, d);
    end
    tick();
    check("busy_last_minus1", {63'd0, busy}, 64'd1);
    tick();
    check("busy_fall", {63'd0, busy}, 64'd0);
    drain(2);
    check("throughput_valids", 64'(vcnt), 64'd64);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
